// File: rtl/time_setup_ctrl_pkg.sv
// Shared types and constants for the front-panel time-setting control stage.
package time_setup_pkg;

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_e;

  typedef enum logic [1:0] {FIELD_NONE, FIELD_H, FIELD_M, FIELD_S} field_e;

  localparam logic [1:0] REZ_CLOCK = 2'd0;
  localparam logic [1:0] REZ_ALARM = 2'd1;
  localparam logic [1:0] REZ_TIMER = 2'd2;

  localparam logic [7:0] HOURS_MAX_DEFAULT  = 8'd23;
  localparam logic [7:0] MINSEC_MAX_DEFAULT = 8'd59;

  // Wrap-around +/-1 within [0, max]; a value above max is first clamped to max.
  function automatic logic [7:0] step_val(input logic [7:0] val,
                                          input logic [7:0] max,
                                          input logic       up);
    logic [7:0] base;
    base = (val > max) ? max : val;
    if (up) return (base == max) ? 8'd0 : base + 8'd1;
    else    return (base == 8'd0) ? max : base - 8'd1;
  endfunction

endpackage

// File: rtl/time_setup_ctrl_btn_debounce.sv
// Button debouncer: 2-flop synchronizer plus stability counter; press is a
// one-cycle pulse in the cycle the accepted level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/time_setup_ctrl.sv
// Front-panel edit FSM: debounced buttons select display mode, freeze counting
// while editing, and issue one-cycle setup_imp_* load strobes to the counters.
module time_setup_ctrl
  import time_setup_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter logic [7:0]  HOURS_MAX       = HOURS_MAX_DEFAULT,
  parameter logic [7:0]  MINSEC_MAX      = MINSEC_MAX_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_select,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  input  logic [7:0] cur_seconds,
  output logic [1:0] rezhim,
  output logic       work_en,
  output logic       setup_imp_h,
  output logic       setup_imp_m,
  output logic       setup_imp_s,
  output logic [7:0] setup_data,
  output logic [1:0] edit_field
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic p_sel, p_mode, p_inc, p_dec, any_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel  (.clock(clock), .reset(reset), .btn_raw(btn_select), .press(p_sel));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (.clock(clock), .reset(reset), .btn_raw(btn_mode),   .press(p_mode));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc  (.clock(clock), .reset(reset), .btn_raw(btn_inc),    .press(p_inc));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec  (.clock(clock), .reset(reset), .btn_raw(btn_dec),    .press(p_dec));

  state_e        state_q, state_d;
  logic [1:0]    rezhim_q, rezhim_d;
  logic          work_en_q, work_en_d;
  field_e        edit_field_q, edit_field_d;
  logic [7:0]    edit_val_q, edit_val_d;
  logic          imp_h_q, imp_h_d, imp_m_q, imp_m_d, imp_s_q, imp_s_d;
  logic [7:0]    setup_data_q, setup_data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    field_max, new_val;

  assign any_press = p_sel | p_mode | p_inc | p_dec;
  assign field_max = (state_q == SET_H) ? HOURS_MAX : MINSEC_MAX;
  assign new_val   = step_val(edit_val_q, field_max, p_inc);

  always_comb begin
    state_d      = state_q;
    rezhim_d     = rezhim_q;
    edit_val_d   = edit_val_q;
    imp_h_d      = 1'b0;
    imp_m_d      = 1'b0;
    imp_s_d      = 1'b0;
    setup_data_d = 8'd0;
    case (state_q)
      RUN: begin
        if (p_sel) begin
          state_d    = SET_H;
          edit_val_d = cur_hours;
        end else if (p_mode) begin
          rezhim_d = (rezhim_q == REZ_TIMER) ? REZ_CLOCK : rezhim_q + 2'd1;
        end
      end
      default: begin
        if (p_sel) begin
          case (state_q)
            SET_H:   begin state_d = SET_M; edit_val_d = cur_minutes; end
            SET_M:   begin state_d = SET_S; edit_val_d = cur_seconds; end
            default: state_d = RUN;
          endcase
        end else if (!p_mode && (p_inc ^ p_dec)) begin
          // The load strobe is registered, so it lands one cycle after the press.
          edit_val_d   = new_val;
          setup_data_d = new_val;
          imp_h_d      = (state_q == SET_H);
          imp_m_d      = (state_q == SET_M);
          imp_s_d      = (state_q == SET_S);
        end else if (!any_press && tmo_q == TMO_LAST) begin
          state_d = RUN;
        end
      end
    endcase

    tmo_d     = (state_d == RUN || any_press) ? '0 : tmo_q + 1'b1;
    work_en_d = (state_d == RUN);
    case (state_d)
      SET_H:   edit_field_d = FIELD_H;
      SET_M:   edit_field_d = FIELD_M;
      SET_S:   edit_field_d = FIELD_S;
      default: edit_field_d = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      rezhim_q     <= REZ_CLOCK;
      work_en_q    <= 1'b1;
      edit_field_q <= FIELD_NONE;
      edit_val_q   <= 8'd0;
      imp_h_q      <= 1'b0;
      imp_m_q      <= 1'b0;
      imp_s_q      <= 1'b0;
      setup_data_q <= 8'd0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      rezhim_q     <= rezhim_d;
      work_en_q    <= work_en_d;
      edit_field_q <= edit_field_d;
      edit_val_q   <= edit_val_d;
      imp_h_q      <= imp_h_d;
      imp_m_q      <= imp_m_d;
      imp_s_q      <= imp_s_d;
      setup_data_q <= setup_data_d;
      tmo_q        <= tmo_d;
    end
  end

  // A strobe already registered when reset arrives must not reach the counters.
  assign setup_imp_h = imp_h_q & ~reset;
  assign setup_imp_m = imp_m_q & ~reset;
  assign setup_imp_s = imp_s_q & ~reset;
  assign setup_data  = setup_data_q & {8{~reset}};
  assign rezhim      = rezhim_q;
  assign work_en     = work_en_q;
  assign edit_field  = edit_field_q;

endmodule

// File: tb/tb_time_setup_ctrl.sv
// Bench for time_setup_ctrl: directed scenarios then random presses against a
// press-level reference model of the edit rules.
module tb_time_setup_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_mode, btn_select, btn_inc, btn_dec;
  logic [7:0] cur_hours, cur_minutes, cur_seconds;
  logic [1:0] rezhim;
  logic       work_en, setup_imp_h, setup_imp_m, setup_imp_s;
  logic [7:0] setup_data;
  logic [1:0] edit_field;

  time_setup_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .btn_mode(btn_mode), .btn_select(btn_select), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .rezhim(rezhim), .work_en(work_en),
    .setup_imp_h(setup_imp_h), .setup_imp_m(setup_imp_m), .setup_imp_s(setup_imp_s),
    .setup_data(setup_data), .edit_field(edit_field)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int f; int d; int c; } strobe_t;
  strobe_t sq[$];

  // Reference model: 0 = run, 1..3 = editing hours/minutes/seconds.
  int m_st = 0, m_rez = 0, m_val = 0;
  int fmax[4] = '{0, 23, 59, 59};

  localparam logic [3:0] SEL = 4'b1000, MODE = 4'b0100, INC = 4'b0010, DEC = 4'b0001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (setup_imp_h | setup_imp_m | setup_imp_s) begin
      chk("strobe_onehot", $countones({setup_imp_h, setup_imp_m, setup_imp_s}), 1);
      chk("strobe_while_counting", work_en, 0);
      sq.push_back('{f: setup_imp_h ? 1 : (setup_imp_m ? 2 : 3), d: setup_data, c: cyc});
    end
  end

  task automatic drive(input logic [3:0] m, input int n);
    {btn_select, btn_mode, btn_inc, btn_dec} = m;
    repeat (n) @(negedge clock);
  endtask

  task automatic model_press(input logic [3:0] m, output int es, output int ef, output int ed);
    int b;
    es = 0; ef = 0; ed = 0;
    if (m[3]) begin
      if (m_st == 0) begin m_st = 1; m_val = cur_hours; end
      else if (m_st == 3) m_st = 0;
      else begin m_st++; m_val = (m_st == 2) ? cur_minutes : cur_seconds; end
    end else if (m[2]) begin
      if (m_st == 0) m_rez = (m_rez + 1) % 3;
    end else if ((m[1] != m[0]) && m_st != 0) begin
      b = (m_val > fmax[m_st]) ? fmax[m_st] : m_val;
      m_val = m[1] ? (b + 1) % (fmax[m_st] + 1) : (b + fmax[m_st]) % (fmax[m_st] + 1);
      es = 1; ef = m_st; ed = m_val;
    end
  endtask

  task automatic check_step(input string tag, input int start, input int es, input int ef, input int ed);
    chk({tag, "_nstrobe"}, sq.size(), es);
    if (es == 1 && sq.size() > 0) begin
      chk({tag, "_field"}, sq[0].f, ef);
      chk({tag, "_data"}, sq[0].d, ed);
      chk({tag, "_latency"}, sq[0].c - start, 6);
    end
    chk({tag, "_rezhim"}, rezhim, m_rez);
    chk({tag, "_work_en"}, work_en, (m_st == 0) ? 1 : 0);
    chk({tag, "_edit_field"}, edit_field, m_st);
    sq.delete();
  endtask

  task automatic press(input string tag, input logic [3:0] m);
    int s, es, ef, ed;
    s = cyc;
    drive(m, 8);
    drive(4'b0000, 8);
    model_press(m, es, ef, ed);
    check_step(tag, s, es, ef, ed);
  endtask

  initial begin
    int s, es, ef, ed, r;
    logic [3:0] m;
    reset = 1'b1;
    {btn_select, btn_mode, btn_inc, btn_dec} = 4'b0000;
    cur_hours = 8'd0; cur_minutes = 8'd0; cur_seconds = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rezhim", rezhim, 0);
    chk("rst_work_en", work_en, 1);
    chk("rst_edit_field", edit_field, 0);
    chk("rst_strobes", {setup_imp_h, setup_imp_m, setup_imp_s}, 0);
    chk("rst_data", setup_data, 0);

    // Mode cycling in RUN, inc/dec ignored in RUN.
    for (int i = 0; i < 4; i++) press("mode_run", MODE);
    press("inc_in_run", INC);

    // Hours: wrap up from 23, back down, mode ignored, bouncy press.
    cur_hours = 8'd23;
    press("enter_h", SEL);
    press("mode_in_edit", MODE);
    press("h_inc_wrap", INC);
    press("h_dec_wrap", DEC);
    drive(INC, 2); drive(4'b0000, 2); drive(INC, 2); drive(4'b0000, 2);
    s = cyc;
    drive(INC, 10); drive(4'b0000, 2); drive(INC, 2); drive(4'b0000, 10);
    model_press(INC, es, ef, ed);
    check_step("bouncy", s, es, ef, ed);

    // Select wins over inc; minutes/seconds edits.
    cur_minutes = 8'd0;
    press("sel_plus_inc", SEL | INC);
    press("inc_plus_dec", INC | DEC);
    press("m_dec_wrap", DEC);
    cur_seconds = 8'd30;
    press("enter_s", SEL);
    press("s_inc1", INC);
    press("s_inc2", INC);
    press("exit_run", SEL);

    // Out-of-range live value is clamped on the first edit.
    cur_hours = 8'd30;
    press("enter_h_oor", SEL);
    press("h_dec_clamp", DEC);
    cur_minutes = 8'd12; cur_seconds = 8'd7;
    press("to_m", SEL);
    press("to_s", SEL);

    // Idle timeout in SET_S.
    drive(4'b0000, 40);
    chk("tmo_still_edit", edit_field, 3);
    drive(4'b0000, 30);
    m_st = 0;
    chk("tmo_field", edit_field, 0);
    chk("tmo_work_en", work_en, 1);
    chk("tmo_nstrobe", sq.size(), 0);
    sq.delete();

    // Reset during the cycle the inc strobe would be visible.
    cur_hours = 8'd5;
    press("enter_h_rst", SEL);
    btn_inc = 1'b1;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_strobe_h", setup_imp_h, 0);
    chk("rst_mid_data", setup_data, 0);
    @(posedge clock);
    @(negedge clock);
    m_st = 0; m_rez = 0;
    chk("rst_mid_rezhim", rezhim, 0);
    chk("rst_mid_work_en", work_en, 1);
    chk("rst_mid_field", edit_field, 0);
    chk("rst_mid_strobes", {setup_imp_h, setup_imp_m, setup_imp_s}, 0);
    reset = 1'b0; btn_inc = 1'b0;
    drive(4'b0000, 10);
    chk("rst_mid_nstrobe", sq.size(), 0);
    sq.delete();

    // Random presses against the model.
    for (int i = 0; i < 60; i++) begin
      cur_hours   = 8'($urandom_range(0, 31));
      cur_minutes = 8'($urandom_range(0, 63));
      cur_seconds = 8'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r < 2)      m = SEL;
      else if (r < 3) m = MODE;
      else if (r < 6) m = INC;
      else if (r < 9) m = DEC;
      else            m = 4'($urandom_range(1, 15));
      press("rand", m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
